// File: rtl/jk_bank_sequencer_pkg.sv
// rtl/jk_bank_sequencer_pkg.sv - shared op/state encodings and default widths
package jk_bank_sequencer_pkg;

  localparam int N_DEF      = 8;
  localparam int STEP_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_LOAD   = 3'd2,
    OP_CNT_UP = 3'd3,
    OP_CNT_DN = 3'd4,
    OP_SHL    = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Reserved encodings collapse to HOLD so the bank never sees undefined J/K.
  function automatic op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return op_e'(raw);
      default:                            return OP_HOLD;
    endcase
  endfunction

  // CLEAR and LOAD complete in one step regardless of the requested count.
  function automatic logic is_single_step(input op_e op);
    return (op == OP_CLEAR) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - N-bit bank of JK flip-flops
// Ports: clk, reset (sync active-high, clears q), j/k per-bit controls
// (00 hold, 01 reset, 10 set, 11 toggle), q current state.
module jk_reg_bank
  import jk_bank_sequencer_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] j,
  input  logic [N-1:0] k,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({j[i], k[i]})
          2'b00:   q[i] <= q[i];
          2'b01:   q[i] <= 1'b0;
          2'b10:   q[i] <= 1'b1;
          default: q[i] <= ~q[i];
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command-driven J/K sequencer for a JK register bank
// Ports: clk, reset (sync active-high); cmd_valid/cmd_ready handshake with
// cmd_op, cmd_data, cmd_steps; ser_in serial bit for SHL; q_in live bank state;
// j_out/k_out bank controls; busy, done (1-cycle), wrap (1-cycle) status.
module jk_bank_sequencer
  import jk_bank_sequencer_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [N-1:0]      cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              ser_in,
  input  logic [N-1:0]      q_in,
  output logic [N-1:0]      j_out,
  output logic [N-1:0]      k_out,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  state_e            state;
  op_e               op_q;
  logic [N-1:0]      data_q;
  logic [STEP_W-1:0] remaining;
  op_e               op_dec;
  logic              chain;
  logic [N-1:0]      shl_next;

  assign op_dec    = decode_op(cmd_op);
  // Gated by reset so the host never sees ready while the sequencer is held.
  assign cmd_ready = (state == S_IDLE) && !reset;
  assign shl_next  = {q_in[N-2:0], ser_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_HOLD;
      data_q    <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_dec;
            data_q <= cmd_data;
            if (is_single_step(op_dec)) begin
              remaining <= STEP_W'(1);
              busy      <= 1'b1;
              state     <= S_EXEC;
            end else if (cmd_steps == '0) begin
              // Nothing to do: skip EXEC so the counter can never underflow.
              remaining <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              remaining <= cmd_steps;
              busy      <= 1'b1;
              state     <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if ((op_q == OP_CNT_UP) && (&q_in)) wrap <= 1'b1;
          if ((op_q == OP_CNT_DN) && !(|q_in)) wrap <= 1'b1;
          if (remaining == STEP_W'(1)) begin
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            remaining <= remaining - STEP_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // J/K are live from q_in so each step sees the bank state it modifies.
  always_comb begin
    j_out = '0;
    k_out = '0;
    chain = 1'b1;
    if ((state == S_EXEC) && !reset) begin
      case (op_q)
        OP_CLEAR: begin
          k_out = '1;
        end
        OP_LOAD: begin
          j_out = data_q;
          k_out = ~data_q;
        end
        OP_CNT_UP: begin
          // Bit i toggles when all lower bits are 1.
          for (int i = 0; i < N; i++) begin
            j_out[i] = chain;
            k_out[i] = chain;
            chain    = chain & q_in[i];
          end
        end
        OP_CNT_DN: begin
          // Bit i toggles when all lower bits are 0.
          for (int i = 0; i < N; i++) begin
            j_out[i] = chain;
            k_out[i] = chain;
            chain    = chain & ~q_in[i];
          end
        end
        OP_SHL: begin
          j_out = shl_next;
          k_out = ~shl_next;
        end
        default: begin
          j_out = '0;
          k_out = '0;
        end
      endcase
    end
  end

endmodule
